// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Program-memory instruction sequencer. Holds a small program in
//            memory and issues one word per cycle to a processor through a
//            valid/ready handshake. Executes conditional jumps (BR_OP) and
//            the halt opcode (HALT_OP) internally; neither is issued.
// Revision : 1.0  initial release
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   i_load_en      program-memory write strobe (accepted in IDLE/HALT only)
//   i_load_addr    write address
//   i_load_data    instruction word {opcode[11:8], op1[7:4], op2[3:0]}
//   i_start        one-cycle pulse, begins execution at address 0
//   i_eflags       processor flags, sampled by BR_OP
//   o_instruction  registered instruction to the processor
//   o_instr_valid  o_instruction holds a valid word
//   i_instr_ready  processor accepts o_instruction this cycle
//   o_pc           address of the next word to fetch
//   o_halted       high in HALT
//   o_issue_count  accepted instructions since start, saturating at 255
//
// Configuration
//   FETCH_WRAP_EN  defined  : pc wraps from DEPTH-1 to 0 and RUN continues.
//                  undefined: after the word at DEPTH-1 is accepted the
//                             sequencer halts with pc = DEPTH-1.
// ============================================================================
module instr_fetch #(
    parameter int          DEPTH   = 16,
    parameter logic [3:0]  HALT_OP = 4'hF,
    parameter logic [3:0]  BR_OP   = 4'hE,
    localparam int         PW      = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load_en,
    input  logic [PW-1:0]  i_load_addr,
    input  logic [11:0]    i_load_data,
    input  logic           i_start,
    input  logic [3:0]     i_eflags,
    output logic [11:0]    o_instruction,
    output logic           o_instr_valid,
    input  logic           i_instr_ready,
    output logic [PW-1:0]  o_pc,
    output logic           o_halted,
    output logic [7:0]     o_issue_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         r_state;
    logic [11:0]    r_mem [DEPTH];
    logic [11:0]    r_instr;
    logic           r_valid;
    logic [PW-1:0]  r_pc;
    logic [7:0]     r_cnt;

    logic [11:0]    w_word;
    logic [3:0]     w_opcode;
    logic           w_slot;
    logic           w_accept;
    logic           w_taken;
    logic [PW-1:0]  w_pc_inc;
    logic [PW-1:0]  w_br_tgt;

    assign w_word   = r_mem[r_pc];
    assign w_opcode = w_word[11:8];
    assign w_accept = r_valid && i_instr_ready;
    assign w_slot   = !r_valid || i_instr_ready;
    assign w_taken  = i_eflags[w_word[5:4]];
    assign w_pc_inc = r_pc + PW'(1);
    assign w_br_tgt = PW'(w_word[3:0]);

    // Program memory: no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (i_load_en && (r_state != S_RUN)) begin
            r_mem[i_load_addr] <= i_load_data;
        end
    end

`ifndef FETCH_WRAP_EN
    // Set when the word in r_instr came from address DEPTH-1; its acceptance
    // ends the run instead of fetching past the end of memory.
    logic r_last;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_instr <= 12'h000;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_cnt   <= 8'h00;
`ifndef FETCH_WRAP_EN
            r_last  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    // A simultaneous load wins over start.
                    if (i_start && !i_load_en) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                        r_cnt   <= 8'h00;
                        r_valid <= 1'b0;
`ifndef FETCH_WRAP_EN
                        r_last  <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (w_accept && (r_cnt != 8'hFF)) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`ifndef FETCH_WRAP_EN
                    if (w_accept && r_last) begin
                        r_state <= S_HALT;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else
`endif
                    if (w_slot) begin
                        if (w_opcode == HALT_OP) begin
                            // pc keeps pointing at the halt word
                            r_state <= S_HALT;
                            r_valid <= 1'b0;
                        end else if (w_opcode == BR_OP) begin
                            r_valid <= 1'b0;
                            r_pc    <= w_taken ? w_br_tgt : w_pc_inc;
                        end else begin
                            r_instr <= w_word;
                            r_valid <= 1'b1;
`ifdef FETCH_WRAP_EN
                            r_pc    <= w_pc_inc;
`else
                            if (r_pc == PW'(DEPTH - 1)) begin
                                r_last <= 1'b1;
                            end else begin
                                r_pc   <= w_pc_inc;
                            end
`endif
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_instruction = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_halted      = (r_state == S_HALT);
    assign o_issue_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch. Inputs change and
//            outputs are sampled on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_load_en;
    logic [3:0]  i_load_addr;
    logic [11:0] i_load_data;
    logic        i_start;
    logic [3:0]  i_eflags;
    logic [11:0] o_instruction;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [3:0]  o_pc;
    logic        o_halted;
    logic [7:0]  o_issue_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(16), .HALT_OP(4'hF), .BR_OP(4'hE)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_load_en     (i_load_en),
        .i_load_addr   (i_load_addr),
        .i_load_data   (i_load_data),
        .i_start       (i_start),
        .i_eflags      (i_eflags),
        .o_instruction (o_instruction),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_pc          (o_pc),
        .o_halted      (o_halted),
        .o_issue_count (o_issue_count)
    );

    // Stimulus helpers (no checking). Called at a falling edge; return at one.
    task automatic load(input logic [3:0] a, input logic [11:0] d);
        i_load_en = 1'b1; i_load_addr = a; i_load_data = d;
        @(negedge clk);
        i_load_en = 1'b0;
    endtask

    // Returns at the falling edge after the clock that enters RUN.
    task automatic do_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_load_en = 0; i_load_addr = 0; i_load_data = 0;
        i_start = 0; i_eflags = 0; i_instr_ready = 0;
        #2 rst = 1'b0;
        #1;
        total++; if (o_pc !== 4'd0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", o_pc); end
        total++; if (o_instruction !== 12'h000) begin bad++; $display("FAIL reset_instr got=%h exp=000", o_instruction); end
        total++; if (o_instr_valid !== 1'b0 || o_halted !== 1'b0) begin bad++; $display("FAIL reset_flags valid=%b halted=%b exp=0/0", o_instr_valid, o_halted); end
        total++; if (o_issue_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_issue_count); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Two words then halt, processor always ready.
    task automatic test_basic();
        load(4'd0, 12'h1D4); load(4'd1, 12'h2A3); load(4'd2, 12'hF00);
        i_instr_ready = 1'b1;
        do_start();
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b1 || o_instruction !== 12'h1D4) begin bad++; $display("FAIL basic_w0 got=%h v=%b exp=1D4 v=1", o_instruction, o_instr_valid); end
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b1 || o_instruction !== 12'h2A3) begin bad++; $display("FAIL basic_w1 got=%h v=%b exp=2A3 v=1", o_instruction, o_instr_valid); end
        @(negedge clk);
        total++; if (o_halted !== 1'b1 || o_instr_valid !== 1'b0) begin bad++; $display("FAIL basic_halt halted=%b v=%b exp=1/0", o_halted, o_instr_valid); end
        total++; if (o_pc !== 4'd2) begin bad++; $display("FAIL basic_pc got=%0d exp=2", o_pc); end
        total++; if (o_issue_count !== 8'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", o_issue_count); end
    endtask

    task automatic test_branch();
        load(4'd0, 12'hE25); load(4'd1, 12'h422); load(4'd2, 12'hF00);
        load(4'd5, 12'h311); load(4'd6, 12'hF00);
        i_instr_ready = 1'b1;
        // taken: eflags[2]=1
        i_eflags = 4'b0100;
        do_start();
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b0 || o_pc !== 4'd5) begin bad++; $display("FAIL br_taken_bubble v=%b pc=%0d exp=0/5", o_instr_valid, o_pc); end
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b1 || o_instruction !== 12'h311) begin bad++; $display("FAIL br_taken_word got=%h v=%b exp=311 v=1", o_instruction, o_instr_valid); end
        @(negedge clk);
        total++; if (o_halted !== 1'b1 || o_pc !== 4'd6 || o_issue_count !== 8'd1) begin bad++; $display("FAIL br_taken_end halted=%b pc=%0d cnt=%0d exp=1/6/1", o_halted, o_pc, o_issue_count); end
        // not taken
        i_eflags = 4'b0000;
        do_start();
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b0 || o_pc !== 4'd1) begin bad++; $display("FAIL br_not_bubble v=%b pc=%0d exp=0/1", o_instr_valid, o_pc); end
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b1 || o_instruction !== 12'h422) begin bad++; $display("FAIL br_not_word got=%h v=%b exp=422 v=1", o_instruction, o_instr_valid); end
        @(negedge clk);
        total++; if (o_halted !== 1'b1 || o_pc !== 4'd2 || o_issue_count !== 8'd1) begin bad++; $display("FAIL br_not_end halted=%b pc=%0d cnt=%0d exp=1/2/1", o_halted, o_pc, o_issue_count); end
    endtask

    // Back-pressure hold, plus a start pulse during RUN that must be ignored.
    task automatic test_stall();
        load(4'd0, 12'h1D4); load(4'd1, 12'hF00);
        i_instr_ready = 1'b0;
        do_start();
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b1 || o_instruction !== 12'h1D4 || o_pc !== 4'd1) begin bad++; $display("FAIL stall_issue got=%h v=%b pc=%0d exp=1D4/1/1", o_instruction, o_instr_valid, o_pc); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            total++;
            if (o_instr_valid !== 1'b1 || o_instruction !== 12'h1D4 || o_pc !== 4'd1 || o_issue_count !== 8'd0) begin
                bad++; $display("FAIL stall_hold%0d got=%h v=%b pc=%0d cnt=%0d exp=1D4/1/1/0", i, o_instruction, o_instr_valid, o_pc, o_issue_count);
            end
        end
        i_instr_ready = 1'b1;
        @(negedge clk);
        total++; if (o_issue_count !== 8'd1 || o_halted !== 1'b1) begin bad++; $display("FAIL stall_release cnt=%0d halted=%b exp=1/1", o_issue_count, o_halted); end
        @(negedge clk);
        total++; if (o_issue_count !== 8'd1) begin bad++; $display("FAIL stall_after cnt=%0d exp=1", o_issue_count); end
    endtask

    task automatic test_reset_midrun();
        load(4'd0, 12'h1D4); load(4'd1, 12'h2A3); load(4'd2, 12'hF00);
        i_instr_ready = 1'b0;
        do_start();
        @(negedge clk);
        total++; if (o_instr_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre v=%b exp=1", o_instr_valid); end
        #2 rst = 1'b0;
        #1;
        total++;
        if (o_pc !== 4'd0 || o_instruction !== 12'h000 || o_instr_valid !== 1'b0 || o_halted !== 1'b0 || o_issue_count !== 8'd0) begin
            bad++; $display("FAIL midrst_outs pc=%0d instr=%h v=%b h=%b cnt=%0d exp=0/000/0/0/0", o_pc, o_instruction, o_instr_valid, o_halted, o_issue_count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        i_instr_ready = 1'b1;
        do_start();
        @(negedge clk);
        total++; if (o_instruction !== 12'h1D4 || o_instr_valid !== 1'b1) begin bad++; $display("FAIL midrst_w0 got=%h v=%b exp=1D4", o_instruction, o_instr_valid); end
        @(negedge clk);
        total++; if (o_instruction !== 12'h2A3) begin bad++; $display("FAIL midrst_w1 got=%h exp=2A3", o_instruction); end
        @(negedge clk);
        total++; if (o_halted !== 1'b1 || o_issue_count !== 8'd2) begin bad++; $display("FAIL midrst_end halted=%b cnt=%0d exp=1/2", o_halted, o_issue_count); end
    endtask

    task automatic test_load_in_run();
        load(4'd0, 12'h1D4); load(4'd1, 12'h2A3); load(4'd2, 12'hF00);
        i_instr_ready = 1'b0;
        do_start();
        @(negedge clk);
        load(4'd1, 12'h777);
        load(4'd0, 12'h777);
        load(4'd2, 12'h777);
        i_instr_ready = 1'b1;
        @(negedge clk);
        total++; if (o_instruction !== 12'h2A3) begin bad++; $display("FAIL runload_first got=%h exp=2A3", o_instruction); end
        @(negedge clk);
        total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL runload_halt halted=%b exp=1", o_halted); end
        do_start();
        @(negedge clk);
        total++; if (o_instruction !== 12'h1D4) begin bad++; $display("FAIL runload_rerun0 got=%h exp=1D4", o_instruction); end
        @(negedge clk);
        total++; if (o_instruction !== 12'h2A3) begin bad++; $display("FAIL runload_rerun1 got=%h exp=2A3", o_instruction); end
        @(negedge clk);
        total++; if (o_halted !== 1'b1 || o_pc !== 4'd2) begin bad++; $display("FAIL runload_rerun_end halted=%b pc=%0d exp=1/2", o_halted, o_pc); end
    endtask

    // Full memory of non-halt words, ready held for 20 cycles.
    task automatic test_end_of_mem();
        int idx = 0;
        logic [11:0] exp_w;
        for (int a = 0; a < 16; a++) load(4'(a), 12'h100 + 12'(a));
        i_instr_ready = 1'b1;
        do_start();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_instr_valid === 1'b1) begin
                exp_w = 12'h100 + 12'(idx % 16);
                total++; if (o_instruction !== exp_w) begin bad++; $display("FAIL eom_word%0d got=%h exp=%h", idx, o_instruction, exp_w); end
                idx++;
            end
        end
`ifdef FETCH_WRAP_EN
        total++; if (idx !== 20) begin bad++; $display("FAIL eom_issued got=%0d exp=20", idx); end
        total++; if (o_issue_count !== 8'd19 || o_halted !== 1'b0 || o_pc !== 4'd4) begin bad++; $display("FAIL eom_wrap cnt=%0d halted=%b pc=%0d exp=19/0/4", o_issue_count, o_halted, o_pc); end
`else
        total++; if (idx !== 16) begin bad++; $display("FAIL eom_issued got=%0d exp=16", idx); end
        total++; if (o_issue_count !== 8'd16 || o_halted !== 1'b1 || o_pc !== 4'd15) begin bad++; $display("FAIL eom_halt cnt=%0d halted=%b pc=%0d exp=16/1/15", o_issue_count, o_halted, o_pc); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_stall();
        test_reset_midrun();
        test_load_in_run();
        test_end_of_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of program-memory entries (power of two; PC width = log2(DEPTH)).
REQ-002 SHALL have parameter HALT_OP, default 4'hF, opcode that stops the sequencer.
REQ-003 SHALL have parameter BR_OP, default 4'hE, opcode for a conditional jump executed inside the sequencer.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 load_en  input  1  program-memory write strobe; honoured only in IDLE or HALT.
REQ-007 load_addr  input  log2(DEPTH)  write address.
REQ-008 load_data  input  12  instruction word {opcode[11:8], op1[7:4], op2[3:0]}.
REQ-009 start  input  1  single-cycle pulse; begins execution from address 0.
REQ-010 eflags  input  4  processor flags; sampled by BR_OP.
REQ-011 instruction  output  12  registered instruction to the processor.
REQ-012 instr_valid  output  1  instruction holds a valid word.
REQ-013 instr_ready  input  1  processor accepts instruction this cycle.
REQ-014 pc  output  log2(DEPTH)  address of the next word to fetch.
REQ-015 halted  output  1  high in HALT state.
REQ-016 issue_count  output  8  count of accepted instructions since start, saturates at 8'hFF.

Function
REQ-017 SHALL implement states IDLE, RUN, HALT; reset state IDLE.
REQ-018 IDLE/HALT: a load_en write SHALL update mem[load_addr] at the clock edge; load_en SHALL be ignored in RUN.
REQ-019 IDLE/HALT with start=1 and load_en=0 -> RUN; pc<=0, issue_count<=0, instr_valid<=0; start with load_en=1 in the same cycle SHALL perform the write and ignore start.
REQ-020 RUN fetch slot exists when instr_valid=0 or (instr_valid and instr_ready); at most one memory read per cycle.
REQ-021 Fetch of a normal word: instruction<=mem[pc], instr_valid<=1, pc<=pc+1 (mod DEPTH) in the same cycle, giving back-to-back issue when instr_ready is held high.
REQ-022 Fetch of BR_OP: not issued; if eflags[op1[1:0]]=1 then pc<=op2 else pc<=pc+1; instr_valid<=0 that cycle (one bubble).
REQ-023 Fetch of HALT_OP: not issued; -> HALT, instr_valid<=0, pc unchanged (points at the halt word).
REQ-024 instr_valid=1 and instr_ready=0: instruction, instr_valid, pc SHALL hold.
REQ-025 issue_count SHALL increment on every cycle with instr_valid and instr_ready both 1, saturating at 255.
REQ-026 A word pending in instruction when HALT_OP is fetched SHALL be the word just accepted; no accepted word is lost or repeated.
REQ-027 start during RUN SHALL be ignored.
REQ-028 halted SHALL equal (state==HALT); start from HALT restarts at address 0 with memory preserved.

Reset
REQ-029 rst low SHALL immediately force state IDLE, pc=0, instruction=12'h000, instr_valid=0, halted=0, issue_count=0, including mid-RUN.
REQ-030 Program memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro FETCH_WRAP_EN: when defined, pc wraps from DEPTH-1 to 0 and RUN continues; when undefined, a normal issue from address DEPTH-1 SHALL set pc to DEPTH-1 and enter HALT the cycle after that word is accepted.

Verification
REQ-032 Load mem[0]=12'h1D4, mem[1]=12'h2A3, mem[2]=12'hF00; start; ready=1 -> 12'h1D4 then 12'h2A3 on consecutive cycles, halted=1, pc=2, issue_count=2.
REQ-033 mem[0]=12'hE25 (jump to 5 if eflags[2]), mem[5]=12'h311, mem[1]=12'h422; eflags=4'b0100 -> 12'h311 issued; repeat with eflags=0 -> 12'h422 issued.
REQ-034 Issue 12'h1D4, hold instr_ready=0 for 3 cycles -> instruction/instr_valid/pc stable, issue_count unchanged; release -> count increments once.
REQ-035 Assert rst low mid-RUN with instr_valid=1 -> all outputs at reset values immediately; start again -> program re-executes from address 0 with memory intact.
REQ-036 With FETCH_WRAP_EN defined, 16 non-halt words, ready=1 for 20 cycles -> pc wraps, issue_count reaches 16 then continues; undefined -> halted=1 after 16 accepts.
REQ-037 load_en pulses during RUN -> memory unchanged, verified by re-reading via a second run.
